glitch_sequencer: RTL and testbench
===================================

Name: glitch_sequencer

Overview:
- Trigger-to-glitch scheduler. It arms on command, waits for a qualified edge on the target trigger, counts a programmed delay, then emits a programmed number of glitch pulses with programmed width and gap.
- Runs on the 100 MHz system clock. Drives the shared glitch net that feeds the output mux (crowbar, MAX4619 selects, aux, clock glitch).
- Also drives the arm/waiting/firing status lines used by the RGB LED PWMs and returns done/timeout status to the command processor.

Parameters:
- CTR_W, 32, width of the delay, width, gap and timeout counters.
- CNT_W, 8, width of the repeat count and pulse index.

Ports:
- clk  in  1  system clock (100 MHz domain)
- reset  in  1  synchronous reset, active-high
- i_arm  in  1  single-cycle strobe; latches config and arms
- i_disarm  in  1  single-cycle strobe; abort to IDLE
- i_trig  in  1  raw asynchronous trigger pin
- i_trig_falling  in  1  0 = rising edge qualifies, 1 = falling edge qualifies
- i_delay  in  CTR_W  cycles from qualified edge to first pulse
- i_width  in  CTR_W  glitch pulse high time in cycles (0 treated as 1)
- i_gap  in  CTR_W  low time between pulses (0 treated as 1)
- i_repeat  in  CNT_W  pulse count (0 treated as 1)
- i_timeout  in  CTR_W  max cycles in ARMED; 0 = wait forever
- o_glitch  out  1  registered glitch pulse
- o_armed  out  1  high in ARMED
- o_waiting  out  1  high in DELAY or GAP
- o_firing  out  1  high in PULSE
- o_done  out  1  single-cycle strobe on sequence completion
- o_timeout  out  1  single-cycle strobe on arm timeout
- o_pulse_idx  out  CNT_W  index of current or last pulse, 0-based

Behaviour:
- Reset: state IDLE, all outputs 0, sync flops 0, latched config 0.
- All outputs are registered. o_glitch has no combinational path from any input.
- Config is latched only on an accepted i_arm. Input changes afterwards are ignored until the next arm.
- Trigger path:
  - i_trig passes through a 2-FF synchroniser, then a registered edge compare.
  - Let T be the clock at which FF1 first samples the new level. The qualified edge is flagged at T+2.
  - Edges are required, not levels. A trigger already at its active level when armed does not fire.
- States and transitions:
  - IDLE: i_arm goes to ARMED (o_armed=1 next cycle) and clears o_pulse_idx.
  - ARMED:
    - Qualified edge goes to DELAY, or straight to PULSE when delay=0.
    - If timeout≠0 and the armed-cycle count reaches i_timeout, pulse o_timeout for one cycle and go to IDLE.
  - DELAY: counts delay cycles, then goes to PULSE.
  - PULSE: holds o_glitch=1 for width cycles. Then:
    - if pulse_idx+1 < repeat: go to GAP.
    - otherwise: go to IDLE with o_done=1 for one cycle.
  - GAP: holds o_glitch=0 for gap cycles, increments pulse_idx, then goes to PULSE.
- Latency: o_glitch rises at clock T+3+delay and stays high exactly width cycles. Pulse k rises at T+3+delay+k*(width+gap).
- Edges seen in DELAY, PULSE or GAP are ignored. There is no re-trigger.
- i_disarm in any state goes to IDLE next cycle with o_glitch=0 and status outputs 0. No o_done is issued.
- i_arm and i_disarm in the same cycle: disarm wins.
- i_arm outside IDLE is ignored.
- reset mid-sequence: o_glitch drops at the next clock.
- Counters compare for equality against latched values. They never wrap, because each counter is cleared on entry to its state.
- Width, gap and repeat values of 0 are promoted to 1 at latch time.
- The all-ones delay value is legal.

Decomposition:
- Shared package glitch_pkg holds:
  - the state encoding (IDLE, ARMED, DELAY, PULSE, GAP) as localparams or a typedef;
  - the CTR_W/CNT_W defaults;
  - the edge-select encoding constants.
- One natural sub-module: trig_edge_sync (2-FF synchroniser plus edge qualifier, edge-select input, single-cycle edge output).

Test Plan:
- Arm with delay=10, width=5, repeat=1, rising edge; raise i_trig at T → o_glitch high on cycles T+13..T+17, o_done pulses once at T+18, o_armed cleared.
- Arm with delay=0, width=2, gap=3, repeat=3 → pulses start at T+3, T+8, T+13, each 2 cycles wide; o_pulse_idx steps 0,1,2; a single o_done.
- Arm with timeout=100 and no trigger → o_timeout one cycle at armed-cycle 100, state IDLE, o_glitch never asserted.
- Hold i_trig high before arm, falling-edge select, then drop i_trig → fires only on the falling edge; a later rising edge has no effect.
- i_disarm mid-PULSE (width=50) → o_glitch low next cycle, no o_done. Arm with disarm in the same cycle → stays IDLE.
- Assert reset during GAP → all outputs 0 next cycle. i_arm issued while in DELAY is ignored, and latched config is unchanged in the resulting timing.

Source files
------------

// File: rtl/glitch_pkg.sv
// rtl/glitch_pkg.sv - shared state encoding and constants for the glitch sequencer
package glitch_pkg;

  localparam int CTR_W_DEF = 32;
  localparam int CNT_W_DEF = 8;

  localparam logic EDGE_RISING  = 1'b0;
  localparam logic EDGE_FALLING = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_DELAY = 3'd2,
    ST_PULSE = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

endpackage

// File: rtl/trig_edge_sync.sv
// rtl/trig_edge_sync.sv - 2-FF trigger synchroniser with registered edge qualifier
module trig_edge_sync
  import glitch_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic trig_i,
  input  logic falling_i,
  output logic edge_o
);

  logic ff1_q, ff2_q, prev_q, edge_q;
  logic edge_d;

  always_comb begin
    edge_d = 1'b0;
    case (falling_i)
      EDGE_RISING:  edge_d = ff2_q & ~prev_q;
      EDGE_FALLING: edge_d = prev_q & ~ff2_q;
      default:      edge_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ff1_q  <= 1'b0;
      ff2_q  <= 1'b0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      ff1_q  <= trig_i;
      ff2_q  <= ff1_q;
      prev_q <= ff2_q;
      edge_q <= edge_d;
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/glitch_sequencer.sv
// rtl/glitch_sequencer.sv - trigger-to-glitch scheduler: arm, qualify edge, delay, pulse train
module glitch_sequencer
  import glitch_pkg::*;
#(
  parameter int CTR_W = CTR_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_arm,
  input  logic             i_disarm,
  input  logic             i_trig,
  input  logic             i_trig_falling,
  input  logic [CTR_W-1:0] i_delay,
  input  logic [CTR_W-1:0] i_width,
  input  logic [CTR_W-1:0] i_gap,
  input  logic [CNT_W-1:0] i_repeat,
  input  logic [CTR_W-1:0] i_timeout,
  output logic             o_glitch,
  output logic             o_armed,
  output logic             o_waiting,
  output logic             o_firing,
  output logic             o_done,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_pulse_idx
);

  localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CTR_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CTR_W-1:0] delay_q, width_q, gap_q, timeout_q;
  logic [CNT_W-1:0] repeat_q;
  logic             falling_q;

  logic trig_edge;
  logic arm_ok, timeout_hit, delay_end, pulse_end, gap_end, more_pulses;

  logic glitch_q, armed_q, waiting_q, firing_q, done_q, timeout_q_out;
  logic glitch_d, armed_d, waiting_d, firing_d, done_d, timeout_d;

  trig_edge_sync u_trig_edge_sync (
    .clk       (clk),
    .reset     (reset),
    .trig_i    (i_trig),
    .falling_i (falling_q),
    .edge_o    (trig_edge)
  );

  // Each counter restarts at zero on state entry, so an end test is cnt == value-1.
  assign arm_ok      = (state_q == ST_IDLE) && i_arm && !i_disarm;
  assign timeout_hit = (timeout_q != '0) && (cnt_q == timeout_q - CTR_ONE);
  assign delay_end   = (cnt_q == delay_q - CTR_ONE);
  assign pulse_end   = (cnt_q == width_q - CTR_ONE);
  assign gap_end     = (cnt_q == gap_q - CTR_ONE);
  assign more_pulses = (idx_q + CNT_ONE) < repeat_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_disarm) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (i_arm) state_d = ST_ARMED;
        ST_ARMED: begin
          if (trig_edge)        state_d = (delay_q == '0) ? ST_PULSE : ST_DELAY;
          else if (timeout_hit) state_d = ST_IDLE;
        end
        ST_DELAY: if (delay_end) state_d = ST_PULSE;
        ST_PULSE: if (pulse_end) state_d = more_pulses ? ST_GAP : ST_IDLE;
        ST_GAP:   if (gap_end) state_d = ST_PULSE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q + CTR_ONE;
    if (state_d != state_q || state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if (state_q == ST_ARMED && timeout_q == '0) begin
      cnt_d = cnt_q;
    end
    idx_d = idx_q;
    if (arm_ok) begin
      idx_d = '0;
    end else if (state_q == ST_GAP && state_d == ST_PULSE) begin
      idx_d = idx_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      delay_q   <= '0;
      width_q   <= '0;
      gap_q     <= '0;
      repeat_q  <= '0;
      timeout_q <= '0;
      falling_q <= 1'b0;
    end else if (arm_ok) begin
      delay_q   <= i_delay;
      width_q   <= (i_width == '0) ? CTR_ONE : i_width;
      gap_q     <= (i_gap == '0) ? CTR_ONE : i_gap;
      repeat_q  <= (i_repeat == '0) ? CNT_ONE : i_repeat;
      timeout_q <= i_timeout;
      falling_q <= i_trig_falling;
    end
  end

  // Outputs decode the next state so every output is a flop aligned with state_q.
  always_comb begin
    glitch_d  = (state_d == ST_PULSE);
    armed_d   = (state_d == ST_ARMED);
    waiting_d = (state_d == ST_DELAY) || (state_d == ST_GAP);
    firing_d  = (state_d == ST_PULSE);
    done_d    = !i_disarm && (state_q == ST_PULSE) && (state_d == ST_IDLE);
    timeout_d = !i_disarm && (state_q == ST_ARMED) && (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      glitch_q      <= 1'b0;
      armed_q       <= 1'b0;
      waiting_q     <= 1'b0;
      firing_q      <= 1'b0;
      done_q        <= 1'b0;
      timeout_q_out <= 1'b0;
    end else begin
      glitch_q      <= glitch_d;
      armed_q       <= armed_d;
      waiting_q     <= waiting_d;
      firing_q      <= firing_d;
      done_q        <= done_d;
      timeout_q_out <= timeout_d;
    end
  end

  assign o_glitch    = glitch_q;
  assign o_armed     = armed_q;
  assign o_waiting   = waiting_q;
  assign o_firing    = firing_q;
  assign o_done      = done_q;
  assign o_timeout   = timeout_q_out;
  assign o_pulse_idx = idx_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// tb/tb_glitch_sequencer.sv - directed vector bench for glitch_sequencer
module tb_glitch_sequencer;

  localparam int CTR_W = 32;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             i_arm, i_disarm, i_trig, i_trig_falling;
  logic [CTR_W-1:0] i_delay, i_width, i_gap, i_timeout;
  logic [CNT_W-1:0] i_repeat;
  logic             o_glitch, o_armed, o_waiting, o_firing, o_done, o_timeout;
  logic [CNT_W-1:0] o_pulse_idx;

  glitch_sequencer #(.CTR_W(CTR_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_arm          (i_arm),
    .i_disarm       (i_disarm),
    .i_trig         (i_trig),
    .i_trig_falling (i_trig_falling),
    .i_delay        (i_delay),
    .i_width        (i_width),
    .i_gap          (i_gap),
    .i_repeat       (i_repeat),
    .i_timeout      (i_timeout),
    .o_glitch       (o_glitch),
    .o_armed        (o_armed),
    .o_waiting      (o_waiting),
    .o_firing       (o_firing),
    .o_done         (o_done),
    .o_timeout      (o_timeout),
    .o_pulse_idx    (o_pulse_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int delay;
    int width;
    int gap;
    int rep;
    int exp_rise;
    int exp_high;
    int exp_done;
    int exp_idx;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_cfg(input int d, input int w, input int g, input int r, input int to, input logic fall);
    i_delay        = CTR_W'(d);
    i_width        = CTR_W'(w);
    i_gap          = CTR_W'(g);
    i_repeat       = CNT_W'(r);
    i_timeout      = CTR_W'(to);
    i_trig_falling = fall;
  endtask

  task automatic arm();
    i_arm = 1'b1;
    step();
    i_arm = 1'b0;
  endtask

  // Cycle c of the loop samples just after clock edge T+c (trigger must already be driven).
  task automatic measure(input int ncyc, input int arm_at, input int disarm_at,
                         output int rise, output int high, output int last_high,
                         output int done_at, output int done_cnt, output int seq_err);
    int   pulses;
    logic prev_g;
    pulses = 0; prev_g = 1'b0;
    rise = -1; high = 0; last_high = -1; done_at = -1; done_cnt = 0; seq_err = 0;
    for (int c = 0; c < ncyc; c++) begin
      step();
      if (o_glitch) begin
        high++;
        last_high = c;
        if (rise < 0) rise = c;
      end
      if (o_glitch && !prev_g) begin
        if (int'(o_pulse_idx) != pulses) seq_err++;
        pulses++;
      end
      if (o_firing !== o_glitch) seq_err++;
      if (o_done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      prev_g   = o_glitch;
      i_arm    = (c == arm_at);
      i_disarm = (c == disarm_at);
    end
    i_arm = 1'b0;
    i_disarm = 1'b0;
  endtask

  vec_t vecs[5];
  int rise, high, last_high, done_at, done_cnt, seq_err;
  int to_at, to_cnt, last_armed, g_seen;

  initial begin
    vecs[0] = '{delay: 10, width: 5, gap: 0,  rep: 1, exp_rise: 13, exp_high: 5, exp_done: 18, exp_idx: 0};
    vecs[1] = '{delay: 0,  width: 2, gap: 3,  rep: 3, exp_rise: 3,  exp_high: 6, exp_done: 15, exp_idx: 2};
    vecs[2] = '{delay: 1,  width: 0, gap: 0,  rep: 0, exp_rise: 4,  exp_high: 1, exp_done: 5,  exp_idx: 0};
    vecs[3] = '{delay: 4,  width: 3, gap: 2,  rep: 2, exp_rise: 7,  exp_high: 6, exp_done: 15, exp_idx: 1};
    vecs[4] = '{delay: 2,  width: 1, gap: 1,  rep: 4, exp_rise: 5,  exp_high: 4, exp_done: 12, exp_idx: 3};

    reset = 1'b1; i_arm = 1'b0; i_disarm = 1'b0; i_trig = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 1'b0);
    idle(3);
    check("reset_outputs", {o_glitch, o_armed, o_waiting, o_firing, o_done, o_timeout}, 6'b0);
    check("reset_idx", o_pulse_idx, 0);
    reset = 1'b0;
    idle(2);

    for (int v = 0; v < 5; v++) begin
      set_cfg(vecs[v].delay, vecs[v].width, vecs[v].gap, vecs[v].rep, 0, 1'b0);
      arm();
      check($sformatf("v%0d_armed", v), o_armed, 1);
      i_trig = 1'b1;
      measure(40, -1, -1, rise, high, last_high, done_at, done_cnt, seq_err);
      check($sformatf("v%0d_rise", v), rise, vecs[v].exp_rise);
      check($sformatf("v%0d_high", v), high, vecs[v].exp_high);
      check($sformatf("v%0d_done_at", v), done_at, vecs[v].exp_done);
      check($sformatf("v%0d_done_cnt", v), done_cnt, 1);
      check($sformatf("v%0d_idx_seq", v), seq_err, 0);
      check($sformatf("v%0d_last_idx", v), o_pulse_idx, vecs[v].exp_idx);
      check($sformatf("v%0d_armed_end", v), o_armed, 0);
      i_trig = 1'b0;
      idle(5);
    end

    // Timeout with no trigger: ARMED lasts exactly 100 cycles.
    set_cfg(5, 1, 1, 1, 100, 1'b0);
    arm();
    to_at = -1; to_cnt = 0; last_armed = -1; g_seen = 0;
    for (int k = 1; k <= 120; k++) begin
      step();
      if (o_timeout) begin
        to_cnt++;
        if (to_at < 0) to_at = k;
      end
      if (o_armed) last_armed = k;
      if (o_glitch) g_seen++;
    end
    check("timeout_at", to_at, 100);
    check("timeout_cnt", to_cnt, 1);
    check("timeout_last_armed", last_armed, 99);
    check("timeout_no_glitch", g_seen, 0);

    // Falling-edge select with trigger already high at arm time.
    i_trig = 1'b1;
    idle(5);
    set_cfg(0, 1, 0, 1, 0, 1'b1);
    arm();
    measure(10, -1, -1, rise, high, last_high, done_at, done_cnt, seq_err);
    check("fall_level_no_fire", high, 0);
    i_trig = 1'b0;
    measure(10, -1, -1, rise, high, last_high, done_at, done_cnt, seq_err);
    check("fall_rise", rise, 3);
    check("fall_done_at", done_at, 4);
    idle(3);
    arm();
    i_trig = 1'b1;
    measure(15, -1, -1, rise, high, last_high, done_at, done_cnt, seq_err);
    check("fall_ignores_rising", high, 0);
    check("fall_still_armed", o_armed, 1);
    i_trig = 1'b0;
    measure(10, -1, -1, rise, high, last_high, done_at, done_cnt, seq_err);
    check("fall_second_rise", rise, 3);
    idle(3);

    // Disarm mid-PULSE: glitch high T+3..T+10, disarm seen at edge T+11.
    set_cfg(0, 50, 0, 1, 0, 1'b0);
    arm();
    i_trig = 1'b1;
    measure(70, -1, 10, rise, high, last_high, done_at, done_cnt, seq_err);
    check("disarm_rise", rise, 3);
    check("disarm_last_high", last_high, 10);
    check("disarm_no_done", done_cnt, 0);
    check("disarm_status", {o_armed, o_waiting, o_firing}, 3'b0);
    i_trig = 1'b0;
    idle(5);

    // Arm and disarm together: disarm wins.
    set_cfg(0, 1, 0, 1, 0, 1'b0);
    i_arm = 1'b1; i_disarm = 1'b1;
    step();
    i_arm = 1'b0; i_disarm = 1'b0;
    check("arm_disarm_armed", o_armed, 0);
    i_trig = 1'b1;
    measure(10, -1, -1, rise, high, last_high, done_at, done_cnt, seq_err);
    check("arm_disarm_no_fire", high, 0);
    i_trig = 1'b0;
    idle(5);

    // Reset during the second GAP (idx=1).
    set_cfg(0, 2, 3, 3, 0, 1'b0);
    arm();
    i_trig = 1'b1;
    measure(12, -1, -1, rise, high, last_high, done_at, done_cnt, seq_err);
    check("gap_waiting", o_waiting, 1);
    check("gap_idx", o_pulse_idx, 1);
    reset = 1'b1;
    step();
    check("gap_reset_outputs", {o_glitch, o_armed, o_waiting, o_firing, o_done, o_timeout}, 6'b0);
    check("gap_reset_idx", o_pulse_idx, 0);
    reset = 1'b0;
    measure(20, -1, -1, rise, high, last_high, done_at, done_cnt, seq_err);
    check("after_reset_no_fire", high, 0);
    i_trig = 1'b0;
    idle(5);

    // Arm during DELAY with a different config is ignored.
    set_cfg(10, 5, 0, 1, 0, 1'b0);
    arm();
    set_cfg(0, 1, 0, 1, 0, 1'b0);
    i_trig = 1'b1;
    measure(25, 5, -1, rise, high, last_high, done_at, done_cnt, seq_err);
    check("rearm_rise", rise, 13);
    check("rearm_high", high, 5);
    check("rearm_done_at", done_at, 18);
    check("rearm_done_cnt", done_cnt, 1);
    check("rearm_armed_end", o_armed, 0);
    i_trig = 1'b0;
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
